// File: rtl/bcd_counter_2digit.sv
// Two-digit BCD up/down counter with a built-in rate divider, parallel load,
// pause and direction control, and one-cycle tick / wrap / load_err pulses.
module bcd_counter_2digit #(
  parameter int TICK_DIV = 50_000_000,
  parameter int CNT_W    = 26
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [3:0] digit1,
  output logic [3:0] digit0,
  output logic       tick,
  output logic       wrap,
  output logic       load_err
);

  // Terminal divider count; the step happens on the edge that sees this value.
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] divider;
  logic             load_ok;
  logic             at_last;
  logic [3:0]       next1;
  logic [3:0]       next0;
  logic             next_wrap;

  assign load_ok = (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);
  assign at_last = (divider == DIV_LAST);

  // Each digit is its own modulo-10 counter; the tens digit moves only on a
  // units rollover, and a tens rollover is the 99/00 wrap.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    next1     = digit1;
    next0     = digit0;
    next_wrap = 1'b0;
    if (up) begin
      if (digit0 >= 4'd9) begin
        next0 = 4'd0;
        if (digit1 >= 4'd9) begin
          next1     = 4'd0;
          next_wrap = 1'b1;
        end else begin
          next1 = digit1 + 4'd1;
        end
      end else begin
        next0 = digit0 + 4'd1;
      end
    end else begin
      if (digit0 == 4'd0) begin
        next0 = 4'd9;
        if (digit1 == 4'd0) begin
          next1     = 4'd9;
          next_wrap = 1'b1;
        end else begin
          next1 = digit1 - 4'd1;
        end
      end else begin
        next0 = digit0 - 4'd1;
      end
    end
  end

  // Priority: reset, load, step, divider advance, hold.
  // NOTE: all state here is assigned with <= so every register samples the
  // pre-edge values of its peers, regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      divider  <= '0;
      digit1   <= 4'd0;
      digit0   <= 4'd0;
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      tick     <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      if (load) begin
        divider <= '0;
        if (load_ok) begin
          digit1 <= load_val[7:4];
          digit0 <= load_val[3:0];
        end else begin
          load_err <= 1'b1;
        end
      end else if (enable) begin
        if (at_last) begin
          divider <= '0;
          digit1  <= next1;
          digit0  <= next0;
          tick    <= 1'b1;
          wrap    <= next_wrap;
        end else begin
          divider <= divider + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: doc/bcd_counter_2digit.md
# bcd_counter_2digit

Two-digit BCD up/down counter with a built-in rate divider, producing the tens and units digits that feed the board's pair of 7-segment hex decoders (tens to HEX1, units to HEX0). It supports a synchronous parallel load from the switch bank, pause, and direction control. It also reports divider ticks, 99/00 wrap events and rejected (non-BCD) loads.

## Interface
- TICK_DIV, 50_000_000: enabled clock cycles per count step; legal range 1 to 2^CNT_W.
- CNT_W, 26: divider register width.
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- enable  in  1  1 = divider advances; 0 = divider and digits hold.
- up  in  1  direction, sampled at a step edge: 1 = count up, 0 = count down.
- load  in  1  synchronous load request, level-sampled each cycle.
- load_val  in  8  [7:4] = tens, [3:0] = units, BCD.
- digit1  out  4  tens digit, 0–9.
- digit0  out  4  units digit, 0–9.
- tick  out  1  one-cycle pulse, high in the same cycle the new step value first appears on the digits.
- wrap  out  1  one-cycle pulse, high alongside tick when the step wrapped 99→00 (up) or 00→99 (down).
- load_err  out  1  one-cycle pulse after a rejected load.

## Operation
- Reset values: digit1 = 0, digit0 = 0, divider = 0, tick = 0, wrap = 0, load_err = 0.
- Priority per edge, highest first: reset, load, step, hold.
- **Load**
  - If load = 1 and both nibbles of load_val ≤ 9: digits ← load_val and divider ← 0. No tick or wrap this edge.
  - If load = 1 and either nibble > 9: digits unchanged, divider ← 0, load_err ← 1. No tick.
  - Load is accepted regardless of enable.
- **Step condition:** no load, enable = 1, and divider == TICK_DIV−1. Then divider ← 0, tick ← 1, and the digits change as below.
- **Divider when not stepping:**
  - enable = 1: divider increments by 1.
  - enable = 0: divider holds and tick = 0.
- **Up step:**
  - digit0 < 9: digit0 + 1.
  - digit0 = 9: digit0 ← 0 and digit1 increments.
  - 99 → 00 with wrap ← 1.
- **Down step:**
  - digit0 > 0: digit0 − 1.
  - digit0 = 0: digit0 ← 9 and digit1 decrements.
  - 00 → 99 with wrap ← 1.
- Digits never leave 0–9 by any path. Binary-to-BCD conversion is never used; each digit is its own modulo-10 counter.
- tick, wrap and load_err are registered. Each clears to 0 on the next edge unless re-asserted.
- TICK_DIV = 1: the divider stays at 0 and every enabled, non-load cycle is a step.

## Timing
- Reset assertion clears all outputs without waiting for a clock edge. Release is taken synchronously at the next edge.
- From reset release with enable = 1 held, the first step is visible after exactly TICK_DIV rising edges. After that, one step every TICK_DIV edges.
- Load latency is 1 edge: load_val appears on the digits in the cycle after the edge that sampled load = 1.
- After a load, the next step occurs TICK_DIV enabled edges later.
- Deasserting enable for N cycles stretches the step period by exactly N cycles; the divider value is preserved.
- Changing up mid-period has no effect until the next step edge.
- load held high for several cycles reloads every edge and suppresses all steps.
- Reset asserted mid-period discards the divider progress; no stale tick or wrap may appear after release.

## Test plan
- TICK_DIV = 4, reset then enable = 1, up = 1: digits 00 → 01 after 4 edges. tick is high one cycle every 4th edge. After 40 steps, digits = 40.
- Load 0x98, up = 1: one cycle later digits = 98. Next step → 99, then → 00 with tick = 1 and wrap = 1 in the same cycle.
- Load 0x01, up = 0: steps give 00, then 99 with wrap = 1, then 98.
- Load 0x3A: digits hold their prior value and load_err = 1 for exactly one cycle. Load 0xA3 gives the same result.
- Load asserted on the same edge as a step condition: digits = load_val, tick = 0, and the next tick comes 4 edges later. With enable toggled low for 3 cycles mid-period, the period becomes 7.
- Assert reset between ticks, at divider = 2 with digits = 57: outputs read 00 / 0 / 0 / 0 with no clock edge. After release, the first tick comes at the 4th edge.
